// File: rtl/uart_mem_bridge_if.sv
// Memory-side bus of the UART-to-memory bridge.
//   mem_stb  : one-cycle request strobe (bridge -> memory)
//   mem_we   : write qualifier, valid with mem_stb
//   mem_addr : word address, 8*ADDR_BYTES bits
//   mem_din  : write data, 8*DATA_BYTES bits
//   mem_busy : memory controller busy (memory -> bridge)
//   mem_dout : read data, valid when mem_busy falls
// master = bridge side, slave = memory controller side.
interface uart_mem_bridge_if #(
  parameter int ADDR_BYTES = 3,
  parameter int DATA_BYTES = 2
);
  logic                    mem_stb;
  logic                    mem_we;
  logic [8*ADDR_BYTES-1:0] mem_addr;
  logic [8*DATA_BYTES-1:0] mem_din;
  logic                    mem_busy;
  logic [8*DATA_BYTES-1:0] mem_dout;

  modport master (
    output mem_stb, mem_we, mem_addr, mem_din,
    input  mem_busy, mem_dout
  );

  modport slave (
    input  mem_stb, mem_we, mem_addr, mem_din,
    output mem_busy, mem_dout
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// UART command bridge: decodes opcode/address/data byte frames from a UART
// receiver into single-word memory accesses, returns read data (or an ack /
// timeout byte) through the UART transmitter.
//   clk, arst_n       : clock, asynchronous active-low reset
//   tick_1us          : one-cycle pulse per microsecond (timeout base)
//   rx_valid, rx_data : received byte strobe and value
//   tx_busy           : transmitter busy
//   tx_write, tx_data : one-cycle transmit strobe and byte
//   mem               : memory bus (master side)
//   busy              : high whenever the bridge is not idle
//   err_count         : saturating count of protocol errors
module uart_mem_bridge #(
  parameter int ADDR_BYTES = 3,
  parameter int DATA_BYTES = 2,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT_US = 1000
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     tick_1us,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     tx_busy,
  output logic                     tx_write,
  output logic [7:0]               tx_data,
  uart_mem_bridge_if.master        mem,
  output logic                     busy,
  output logic [7:0]               err_count
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;
  localparam logic [2:0] S_ACK   = 3'd6;

  logic [2:0]    state;
  logic          wr;          // latched opcode bit7
  logic [3:0]    words_left;  // words still to do after the current one
  logic [1:0]    bcnt;        // byte index within address / word
  logic [15:0]   tcount;
  logic          wait_first;
  logic          tx_last;     // tx_write was high in the previous cycle
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] rdata;       // remaining read-response bytes, MSB aligned

  logic       in_frame;
  logic       timeout;
  logic       drop;
  logic [3:0] burst_m1;

  always_comb begin
    in_frame = (state == S_ADDR) || (state == S_WDATA);
    // rx_valid takes priority over a coincident tick
    timeout  = in_frame && !rx_valid && tick_1us &&
               (tcount == 16'(TIMEOUT_US - 1));
    drop     = rx_valid && ((state == S_ISSUE) || (state == S_WAIT) ||
                            (state == S_RESP)  || (state == S_ACK));
    burst_m1 = (rx_data[3:0] > 4'(MAX_BURST - 1)) ? 4'(MAX_BURST - 1)
                                                  : rx_data[3:0];
    // Combinational strobe so the tx_busy qualification is same-cycle.
    tx_write = ((state == S_RESP) || (state == S_ACK)) && !tx_busy && !tx_last;
    busy     = (state != S_IDLE);
  end

  assign mem.mem_stb  = (state == S_ISSUE);
  assign mem.mem_we   = (state == S_ISSUE) && wr;
  assign mem.mem_addr = addr;
  assign mem.mem_din  = din;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= S_IDLE;
      wr         <= 1'b0;
      words_left <= '0;
      bcnt       <= '0;
      tcount     <= '0;
      wait_first <= 1'b0;
      tx_last    <= 1'b0;
      addr       <= '0;
      din        <= '0;
      rdata      <= '0;
      tx_data    <= '0;
      err_count  <= '0;
    end else begin
      tx_last <= tx_write;

      if ((timeout || drop) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;

      // Counter only runs while a frame is being received.
      if (!in_frame || rx_valid)
        tcount <= '0;
      else if (tick_1us)
        tcount <= tcount + 16'd1;

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            wr         <= rx_data[7];
            words_left <= burst_m1;
            bcnt       <= '0;
            state      <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            addr <= (addr << 8) | AW'(rx_data);
            if (bcnt == 2'(ADDR_BYTES - 1)) begin
              bcnt  <= '0;
              state <= wr ? S_WDATA : S_ISSUE;
            end else begin
              bcnt <= bcnt + 2'd1;
            end
          end else if (timeout) begin
            tx_data <= 8'hEE;
            state   <= S_ACK;
          end
        end

        S_WDATA: begin
          if (rx_valid) begin
            din <= (din << 8) | DW'(rx_data);
            if (bcnt == 2'(DATA_BYTES - 1)) begin
              bcnt  <= '0;
              state <= S_ISSUE;
            end else begin
              bcnt <= bcnt + 2'd1;
            end
          end else if (timeout) begin
            tx_data <= 8'hEE;
            state   <= S_ACK;
          end
        end

        S_ISSUE: begin
          wait_first <= 1'b1;
          state      <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!mem.mem_busy) begin
            // Address advances once per completed word, wrapping freely.
            addr <= addr + AW'(1);
            if (!wr) begin
              tx_data <= mem.mem_dout[DW-1 -: 8];
              rdata   <= mem.mem_dout << 8;
              bcnt    <= '0;
              state   <= S_RESP;
            end else if (words_left != 4'd0) begin
              words_left <= words_left - 4'd1;
              bcnt       <= '0;
              state      <= S_WDATA;
            end else begin
              tx_data <= 8'hA5;
              state   <= S_ACK;
            end
          end
        end

        S_RESP: begin
          if (tx_write) begin
            if (bcnt == 2'(DATA_BYTES - 1)) begin
              bcnt <= '0;
              if (words_left != 4'd0) begin
                words_left <= words_left - 4'd1;
                state      <= S_ISSUE;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bcnt    <= bcnt + 2'd1;
              tx_data <= rdata[DW-1 -: 8];
              rdata   <= rdata << 8;
            end
          end
        end

        S_ACK: begin
          if (tx_write)
            state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
module tb_uart_mem_bridge;

  logic        clk;
  logic        arst_n;
  logic        tick_1us;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_write;
  logic [7:0]  tx_data;
  logic        busy;
  logic [7:0]  err_count;

  uart_mem_bridge_if #(.ADDR_BYTES(3), .DATA_BYTES(2)) mif ();

  uart_mem_bridge #(
    .ADDR_BYTES(3),
    .DATA_BYTES(2),
    .MAX_BURST (4),
    .TIMEOUT_US(1000)
  ) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .tick_1us (tick_1us),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .tx_write (tx_write),
    .tx_data  (tx_data),
    .mem      (mif),
    .busy     (busy),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] din;
  } mreq_t;

  mreq_t      memq[$];   // expected memory requests
  logic [7:0] txq[$];    // expected transmitted bytes
  logic [15:0] rdq[$];   // read data the memory model returns

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat     = 4;
  int tx_busy_len = 2;
  logic [7:0] exp_err = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares every DUT output event with the queue head.
  initial begin : monitor
    logic  prev_txw;
    mreq_t e;
    logic [7:0] b;
    prev_txw = 1'b0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        prev_txw = 1'b0;
      end else begin
        if (mif.mem_stb) begin
          if (memq.size() == 0) begin
            chk("unexpected_mem_stb", 32'(mif.mem_addr), 32'hFFFF_FFFF);
          end else begin
            e = memq.pop_front();
            chk("mem_we", 32'(mif.mem_we), 32'(e.we));
            chk("mem_addr", 32'(mif.mem_addr), 32'(e.addr));
            if (e.we) chk("mem_din", 32'(mif.mem_din), 32'(e.din));
          end
        end
        if (tx_write) begin
          chk("tx_write_while_busy", 32'(tx_busy), 32'd0);
          chk("tx_write_back_to_back", 32'(prev_txw), 32'd0);
          if (txq.size() == 0) begin
            chk("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
          end else begin
            b = txq.pop_front();
            chk("tx_data", 32'(tx_data), 32'(b));
          end
        end
        prev_txw = tx_write;
      end
    end
  end

  // Memory controller model.
  initial begin : mem_model
    logic [15:0] rd;
    mif.mem_busy = 1'b0;
    mif.mem_dout = '0;
    forever begin
      @(negedge clk);
      if (arst_n && mif.mem_stb) begin
        rd = 16'h0;
        if (!mif.mem_we && rdq.size() > 0) rd = rdq.pop_front();
        @(posedge clk); #1;
        if (mem_lat == 0) begin
          mif.mem_dout = rd;
        end else begin
          mif.mem_busy = 1'b1;
          repeat (mem_lat) @(posedge clk);
          #1;
          mif.mem_busy = 1'b0;
          mif.mem_dout = rd;
        end
      end
    end
  end

  // UART transmitter busy model.
  initial begin : tx_model
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (arst_n && tx_write && tx_busy_len > 0) begin
        @(posedge clk); #1;
        tx_busy = 1'b1;
        repeat (tx_busy_len) @(posedge clk);
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    tick_1us = 1'b0;
    cyc(gap);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1us = 1'b1;
      cyc(1);
      tick_1us = 1'b0;
      cyc(3);
    end
  endtask

  task automatic push_mem(input logic we, input logic [23:0] a, input logic [15:0] d);
    mreq_t e;
    e.we = we; e.addr = a; e.din = d;
    memq.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy && memq.size() == 0 && txq.size() == 0) begin
        done = 1'b1;
        break;
      end
      cyc(1);
    end
    chk({name, "_completed"}, 32'(done), 32'd1);
    chk({name, "_mem_q_empty"}, 32'(memq.size()), 32'd0);
    chk({name, "_tx_q_empty"}, 32'(txq.size()), 32'd0);
    chk({name, "_err_count"}, 32'(err_count), 32'(exp_err));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_tx_write"},  32'(tx_write), 32'd0);
    chk({name, "_mem_stb"},   32'(mif.mem_stb), 32'd0);
    chk({name, "_mem_we"},    32'(mif.mem_we), 32'd0);
    chk({name, "_busy"},      32'(busy), 32'd0);
    chk({name, "_tx_data"},   32'(tx_data), 32'd0);
    chk({name, "_mem_addr"},  32'(mif.mem_addr), 32'd0);
    chk({name, "_mem_din"},   32'(mif.mem_din), 32'd0);
    chk({name, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : stim
    arst_n   = 1'b1;
    tick_1us = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #3 arst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    cyc(3);
    arst_n = 1'b1;
    cyc(2);

    // Two-word write with ack.
    mem_lat = 4; tx_busy_len = 2;
    push_mem(1'b1, 24'h000010, 16'h1234);
    push_mem(1'b1, 24'h000011, 16'h5678);
    txq.push_back(8'hA5);
    send_byte(8'h81, 1);
    send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h10, 1);
    send_byte(8'h12, 1); send_byte(8'h34, 20);
    send_byte(8'h56, 1); send_byte(8'h78, 1);
    wait_idle("write2", 300);

    // Three-word read wrapping the address through zero.
    mem_lat = 3; tx_busy_len = 3;
    push_mem(1'b0, 24'hFFFFFF, 16'h0);
    push_mem(1'b0, 24'h000000, 16'h0);
    push_mem(1'b0, 24'h000001, 16'h0);
    rdq.push_back(16'hAAAA); rdq.push_back(16'hBBBB); rdq.push_back(16'hCCCC);
    txq.push_back(8'hAA); txq.push_back(8'hAA);
    txq.push_back(8'hBB); txq.push_back(8'hBB);
    txq.push_back(8'hCC); txq.push_back(8'hCC);
    send_byte(8'h02, 1);
    send_byte(8'hFF, 1); send_byte(8'hFF, 1); send_byte(8'hFF, 1);
    wait_idle("read_wrap", 500);

    // Burst of 16 clamps to MAX_BURST=4; transmitter never busy.
    mem_lat = 0; tx_busy_len = 0;
    for (int i = 0; i < 4; i++) begin
      push_mem(1'b0, 24'h000100 + 24'(i), 16'h0);
      rdq.push_back(16'h1111 * 16'(i + 1));
      txq.push_back(8'h11 * 8'(i + 1));
      txq.push_back(8'h11 * 8'(i + 1));
    end
    send_byte(8'h0F, 1);
    send_byte(8'h00, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
    wait_idle("burst_clamp", 500);

    // Bytes arriving while the memory is busy are dropped and counted.
    mem_lat = 50; tx_busy_len = 1;
    push_mem(1'b0, 24'h000020, 16'h0);
    rdq.push_back(16'h1357);
    txq.push_back(8'h13); txq.push_back(8'h57);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h20, 4);
    send_byte(8'h5A, 4); send_byte(8'h5B, 4); send_byte(8'h5C, 4);
    exp_err = 8'd3;
    wait_idle("drop_in_wait", 300);

    // Inter-byte timeout; a byte coinciding with a tick restarts the count.
    txq.push_back(8'hEE);
    send_byte(8'h01, 1);
    send_byte(8'hAA, 1);
    tick_n(600);
    tick_1us = 1'b1;
    send_byte(8'hBB, 1);
    tick_n(999);
    chk("timeout_not_early_busy", 32'(busy), 32'd1);
    chk("timeout_not_early_tx", 32'(txq.size()), 32'd1);
    chk("timeout_not_early_err", 32'(err_count), 32'd3);
    tick_n(1);
    exp_err = 8'd4;
    wait_idle("timeout", 100);

    // Reset while waiting on memory abandons the read.
    mem_lat = 20; tx_busy_len = 2;
    push_mem(1'b0, 24'h000040, 16'h0);
    rdq.push_back(16'hDEAD);
    send_byte(8'h00, 1);
    send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h40, 1);
    cyc(4);
    arst_n = 1'b0;
    #1 chk_reset_outputs("reset_in_wait");
    cyc(3);
    arst_n = 1'b1;
    exp_err = 8'd0;
    cyc(30);
    wait_idle("after_reset", 10);

    // Normal single-word write after the abandoned access.
    mem_lat = 2;
    push_mem(1'b1, 24'h000050, 16'hBEEF);
    txq.push_back(8'hA5);
    send_byte(8'h80, 1);
    send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h50, 1);
    send_byte(8'hBE, 1); send_byte(8'hEF, 1);
    wait_idle("write_after_reset", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

Interface
REQ-001 Parameter ADDR_BYTES, default 3, number of address bytes per command frame, range 1..4.
REQ-002 Parameter DATA_BYTES, default 2, bytes per memory word, range 1..4.
REQ-003 Parameter MAX_BURST, default 16, maximum words per command, range 1..16.
REQ-004 Parameter TIMEOUT_US, default 1000, inter-byte timeout in tick_1us periods, range 1..65535.
REQ-005 Port clk  in  1  single clock for all logic.
REQ-006 Port arst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 Port tick_1us  in  1  one-cycle pulse per microsecond.
REQ-008 Port rx_valid  in  1  one-cycle strobe, received UART byte valid.
REQ-009 Port rx_data  in  8  received byte, valid with rx_valid.
REQ-010 Port tx_busy  in  1  UART transmitter busy.
REQ-011 Port tx_write  out  1  one-cycle transmit strobe.
REQ-012 Port tx_data  out  8  byte to transmit, valid with tx_write.
REQ-013 Port mem_stb  out  1  one-cycle memory request strobe.
REQ-014 Port mem_we  out  1  write qualifier, valid with mem_stb.
REQ-015 Port mem_addr  out  8*ADDR_BYTES  word address.
REQ-016 Port mem_din  out  8*DATA_BYTES  write data.
REQ-017 Port mem_busy  in  1  memory controller busy.
REQ-018 Port mem_dout  in  8*DATA_BYTES  read data, valid when mem_busy falls.
REQ-019 Port busy  out  1  high whenever state is not IDLE.
REQ-020 Port err_count  out  8  saturating count of protocol errors.

Function
REQ-021 Frame: opcode byte, then ADDR_BYTES address bytes MSB first, then (write only) N*DATA_BYTES data bytes, each word MSB first.
REQ-022 Opcode bit7 = write (1) / read (0); bits[3:0] = N-1; N > MAX_BURST clamps to MAX_BURST; bits[6:4] ignored.
REQ-023 States: IDLE, ADDR, WDATA, ISSUE, WAIT, RESP, ACK; IDLE->ADDR on any rx_valid (opcode latched).
REQ-024 ADDR->WDATA (write) or ISSUE (read) on the last address byte; WDATA->ISSUE when a full word is assembled.
REQ-025 ISSUE: assert mem_stb for exactly one cycle with mem_we, mem_addr, mem_din stable; next state WAIT.
REQ-026 WAIT ignores mem_busy in its first cycle, then exits on the first cycle mem_busy==0.
REQ-027 Read exit from WAIT: capture mem_dout, go to RESP, which sends DATA_BYTES bytes MSB first.
REQ-028 Write exit from WAIT: if words remain go to WDATA, else ACK; ACK sends 0xA5 once, then IDLE.
REQ-029 After each word, mem_addr increments by 1 modulo 2^(8*ADDR_BYTES); wrap from all-ones to zero is legal.
REQ-030 Read with words remaining after RESP returns to ISSUE; after the last word goes to IDLE.
REQ-031 tx_write asserts only in a cycle with tx_busy==0, never in two consecutive cycles.
REQ-032 Timeout: in ADDR or WDATA, TIMEOUT_US ticks without rx_valid -> discard frame, send 0xEE, increment err_count, IDLE.
REQ-033 Timeout counter clears on every rx_valid and on entry to ADDR.
REQ-034 rx_valid in ISSUE, WAIT, RESP or ACK: byte dropped, err_count increments, state unaffected.
REQ-035 err_count saturates at 255; timeout and dropped byte in the same cycle count as one increment.
REQ-036 tick_1us and rx_valid in the same cycle: rx_valid wins and the counter clears.

Reset
REQ-037 On arst_n low, immediately: state IDLE; tx_write, mem_stb, mem_we, busy = 0; tx_data, mem_addr, mem_din, err_count = 0; all counters cleared.
REQ-038 Reset mid-frame or mid-access abandons the operation; no response byte is sent after release.
REQ-039 After reset release, the first rx_valid is treated as an opcode.

Verification
REQ-040 Write 0x81, 00 00 10, 12 34 56 78 -> two mem_stb with mem_we=1: addr 0x000010 din 0x1234, then addr 0x000011 din 0x5678; one tx byte 0xA5.
REQ-041 Read 0x02, FF FF FF, memory returns 0xAAAA/0xBBBB/0xCCCC -> addresses FFFFFF, 000000, 000001; tx AA AA BB BB CC CC.
REQ-042 Opcode 0x01 then one address byte, then silence 1000 ticks -> tx 0xEE, err_count=1, no mem_stb, busy=0.
REQ-043 Three rx bytes during WAIT with mem_busy held 50 cycles -> err_count=3, read response unaffected.
REQ-044 Opcode 0x0F with MAX_BURST=4 -> exactly 4 reads, 8 tx bytes.
REQ-045 arst_n low during WAIT -> outputs at reset values that cycle, no tx after release; next frame works normally.
